eprom_prog_seq: RTL and testbench

- Programming sequencer that sits directly downstream of the 2048x8 instruction buffer.
- After the host loader fills the buffer, this block reads bytes back one at a time and drives the 8755 EPROM address/data/program pins with timed setup, pulse and hold phases.
- It reads back and verifies each byte, retries failed bytes, and reports done or error to the top-level controller.

---
 rtl/eprom_prog_seq.sv | 184 ++++++++++++++++++
 tb/tb_eprom_prog_seq.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/eprom_prog_seq.sv
// 8755 EPROM programming sequencer: walks the instruction buffer, drives timed
// setup/pulse/hold on the EPROM pins, verifies each byte and retries on mismatch.
module eprom_prog_seq #(
   parameter int ADDR_W     = 11,
   parameter int SETUP_CYC  = 50,
   parameter int PULSE_CYC  = 2500000,
   parameter int HOLD_CYC   = 50,
   parameter int VERIFY_CYC = 25,
   parameter int MAX_RETRY  = 3
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              start_i,
   input  logic [11:0]       byte_count_i,
   output logic              buf_dir_o,
   output logic [ADDR_W-1:0] buf_addr_o,
   input  logic [7:0]        buf_data_i,
   output logic [ADDR_W-1:0] ep_addr_o,
   output logic [7:0]        ep_dout_o,
   output logic              ep_oe_o,
   output logic              ep_prog_o,
   output logic              ep_rd_n_o,
   input  logic [7:0]        ep_din_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic [ADDR_W-1:0] err_addr_o
);

   localparam logic [3:0] S_IDLE   = 4'd0;
   localparam logic [3:0] S_FETCH  = 4'd1;
   localparam logic [3:0] S_LATCH  = 4'd2;
   localparam logic [3:0] S_SETUP  = 4'd3;
   localparam logic [3:0] S_PULSE  = 4'd4;
   localparam logic [3:0] S_HOLD   = 4'd5;
   localparam logic [3:0] S_VERIFY = 4'd6;
   localparam logic [3:0] S_NEXT   = 4'd7;
   localparam logic [3:0] S_FAIL   = 4'd8;

   localparam int                CW          = ADDR_W + 1;
   localparam logic [CW-1:0]     MAX_CNT     = {1'b1, {ADDR_W{1'b0}}};
   localparam logic [23:0]       SETUP_LAST  = 24'(SETUP_CYC - 1);
   localparam logic [23:0]       PULSE_LAST  = 24'(PULSE_CYC - 1);
   localparam logic [23:0]       HOLD_LAST   = 24'(HOLD_CYC - 1);
   localparam logic [23:0]       VERIFY_LAST = 24'(VERIFY_CYC - 1);
   localparam logic [3:0]        RETRY_MAX   = 4'(MAX_RETRY);

   logic [3:0]        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [7:0]        data_q, data_d;
   logic [23:0]       phase_q, phase_d;
   logic [3:0]        retry_q, retry_d;
   logic              done_q, done_d;
   logic              error_q, error_d;
   logic [ADDR_W-1:0] err_addr_q, err_addr_d;
   logic [ADDR_W-1:0] ep_addr_q, ep_addr_d;
   logic              busy_q, ep_oe_q, ep_prog_q, ep_rd_n_q;

   logic [CW-1:0]     addr_inc;
   logic [CW-1:0]     cnt_clamp;

   assign addr_inc  = {1'b0, addr_q} + {{ADDR_W{1'b0}}, 1'b1};
   assign cnt_clamp = (32'(byte_count_i) > 32'(MAX_CNT)) ? MAX_CNT : CW'(byte_count_i);

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      cnt_d      = cnt_q;
      data_d     = data_q;
      phase_d    = phase_q;
      retry_d    = retry_q;
      done_d     = done_q;
      error_d    = error_q;
      err_addr_d = err_addr_q;
      ep_addr_d  = ep_addr_q;
      case (state_q)
         S_IDLE: if (start_i) begin
            done_d  = (byte_count_i == 12'd0);
            error_d = 1'b0;
            if (byte_count_i != 12'd0) begin
               addr_d  = '0;
               retry_d = '0;
               cnt_d   = cnt_clamp;
               state_d = S_FETCH;
            end
         end
         S_FETCH: begin
            ep_addr_d = addr_q;
            state_d   = S_LATCH;
         end
         S_LATCH: begin
            data_d  = buf_data_i;
            phase_d = '0;
            state_d = S_SETUP;
         end
         S_SETUP: if (phase_q == SETUP_LAST) begin
            phase_d = '0;
            state_d = S_PULSE;
         end else phase_d = phase_q + 24'd1;
         S_PULSE: if (phase_q == PULSE_LAST) begin
            phase_d = '0;
            state_d = S_HOLD;
         end else phase_d = phase_q + 24'd1;
         S_HOLD: if (phase_q == HOLD_LAST) begin
            phase_d = '0;
            state_d = S_VERIFY;
         end else phase_d = phase_q + 24'd1;
         S_VERIFY: if (phase_q == VERIFY_LAST) begin
            phase_d = '0;
            if (ep_din_i == data_q) state_d = S_NEXT;
            else if (retry_q == RETRY_MAX) begin
               // error is raised on FAIL entry so it is visible while busy drops
               error_d    = 1'b1;
               err_addr_d = addr_q;
               state_d    = S_FAIL;
            end else begin
               retry_d = retry_q + 4'd1;
               state_d = S_SETUP;
            end
         end else phase_d = phase_q + 24'd1;
         S_NEXT: begin
            retry_d = '0;
            if (addr_inc == cnt_q) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               addr_d  = addr_inc[ADDR_W-1:0];
               state_d = S_FETCH;
            end
         end
         S_FAIL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // pin strobes are registered from the next state so they never glitch
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         data_q     <= '0;
         phase_q    <= '0;
         retry_q    <= '0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         err_addr_q <= '0;
         ep_addr_q  <= '0;
         busy_q     <= 1'b0;
         ep_oe_q    <= 1'b0;
         ep_prog_q  <= 1'b0;
         ep_rd_n_q  <= 1'b1;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         cnt_q      <= cnt_d;
         data_q     <= data_d;
         phase_q    <= phase_d;
         retry_q    <= retry_d;
         done_q     <= done_d;
         error_q    <= error_d;
         err_addr_q <= err_addr_d;
         ep_addr_q  <= ep_addr_d;
         busy_q     <= (state_d != S_IDLE) && (state_d != S_FAIL);
         ep_oe_q    <= state_d inside {S_LATCH, S_SETUP, S_PULSE, S_HOLD};
         ep_prog_q  <= (state_d == S_PULSE);
         ep_rd_n_q  <= (state_d != S_VERIFY);
      end
   end

   assign buf_dir_o  = busy_q;
   assign buf_addr_o = addr_q;
   assign ep_addr_o  = ep_addr_q;
   assign ep_dout_o  = data_q;
   assign ep_oe_o    = ep_oe_q;
   assign ep_prog_o  = ep_prog_q;
   assign ep_rd_n_o  = ep_rd_n_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign error_o    = error_q;
   assign err_addr_o = err_addr_q;

endmodule

// File: tb/tb_eprom_prog_seq.sv
// Bench for eprom_prog_seq: buffer and EPROM models, per-byte outcome predicted
// from the retry rules and timing arithmetic.
module tb_eprom_prog_seq;

   localparam int AW  = 11;
   localparam int S   = 2;
   localparam int P   = 5;
   localparam int H   = 2;
   localparam int V   = 3;
   localparam int MR  = 2;
   localparam int ATT = S + P + H + V;
   localparam int DEPTH = 2048;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [11:0]   byte_count = '0;
   logic          buf_dir;
   logic [AW-1:0] buf_addr;
   logic [7:0]    buf_data;
   logic [AW-1:0] ep_addr;
   logic [7:0]    ep_dout;
   logic          ep_oe, ep_prog, ep_rd_n;
   logic [7:0]    ep_din;
   logic          busy, done, error;
   logic [AW-1:0] err_addr;

   int checks = 0;
   int errors = 0;

   logic [7:0] bufmem   [DEPTH];
   logic [7:0] eprom    [DEPTH];
   int         pulses   [DEPTH];
   int         fail_cnt [DEPTH];
   int         run = 0, npulse = 0, badw = 0, conflict = 0;
   logic       clr_req = 1'b0;

   eprom_prog_seq #(.ADDR_W(AW), .SETUP_CYC(S), .PULSE_CYC(P), .HOLD_CYC(H),
                    .VERIFY_CYC(V), .MAX_RETRY(MR)) dut (
      .clk_i(clk), .rst_ni(rst_n), .start_i(start), .byte_count_i(byte_count),
      .buf_dir_o(buf_dir), .buf_addr_o(buf_addr), .buf_data_i(buf_data),
      .ep_addr_o(ep_addr), .ep_dout_o(ep_dout), .ep_oe_o(ep_oe), .ep_prog_o(ep_prog),
      .ep_rd_n_o(ep_rd_n), .ep_din_i(ep_din), .busy_o(busy), .done_o(done),
      .error_o(error), .err_addr_o(err_addr));

   always #5 clk = ~clk;

   always @(posedge clk) buf_data <= bufmem[buf_addr];

   // a byte reads back inverted until it has received more than fail_cnt pulses
   assign ep_din = (pulses[ep_addr] <= fail_cnt[ep_addr]) ? ~eprom[ep_addr] : eprom[ep_addr];

   always @(negedge clk) begin
      if (clr_req) begin
         for (int i = 0; i < DEPTH; i++) begin
            eprom[i]  = 8'h00;
            pulses[i] = 0;
         end
         npulse = 0;
         run = 0;
      end else if (!rst_n) run = 0;
      else begin
         if ((ep_oe && !ep_rd_n) || (ep_prog && !ep_oe)) conflict++;
         if (ep_prog) run++;
         else if (run != 0) begin
            if (run != P) badw++;
            eprom[ep_addr] = ep_dout;
            pulses[ep_addr]++;
            npulse++;
            run = 0;
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < DEPTH; i++) begin
         fail_cnt[i] = 0;
         bufmem[i]   = 8'($urandom);
      end
      clr_req = 1'b1;
      @(negedge clk);
      #1 clr_req = 1'b0;
   endtask

   task automatic run_seq(input int cnt, input bit poke, output int n);
      @(negedge clk);
      byte_count = 12'(cnt);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      if (poke) byte_count = 12'($urandom);
      while (!(done || error) && n < 40000) begin
         start = (poke && n == 20);
         @(negedge clk);
         n++;
      end
      start = 1'b0;
   endtask

   // outcome predicted byte by byte from the retry rule and phase lengths
   task automatic check_run(input string tag, input int cnt, input bit poke);
      int nbytes, exp_n, last, exp_ea, n, pmis, dmis, ep;
      bit exp_err;
      nbytes = (cnt > DEPTH) ? DEPTH : cnt;
      exp_n = 0; exp_err = 0; exp_ea = 0; last = nbytes;
      for (int k = 0; k < nbytes; k++) begin
         if (fail_cnt[k] > MR) begin
            exp_n += 2 + (MR + 1) * ATT;
            exp_err = 1; exp_ea = k; last = k + 1;
            break;
         end
         exp_n += 3 + (fail_cnt[k] + 1) * ATT;
      end
      run_seq(cnt, poke, n);
      chk({tag, ".cycles"}, n, exp_n);
      chk({tag, ".done"}, done, !exp_err);
      chk({tag, ".error"}, error, exp_err);
      if (exp_err) chk({tag, ".err_addr"}, err_addr, exp_ea);
      chk({tag, ".busy"}, busy, 0);
      chk({tag, ".buf_dir"}, buf_dir, 0);
      pmis = 0; dmis = 0;
      for (int k = 0; k < DEPTH; k++) begin
         ep = (k >= last) ? 0 : ((fail_cnt[k] > MR) ? MR + 1 : fail_cnt[k] + 1);
         if (pulses[k] != ep) pmis++;
         if (k < last && eprom[k] !== bufmem[k]) dmis++;
      end
      chk({tag, ".pulse_count_mismatches"}, pmis, 0);
      chk({tag, ".data_mismatches"}, dmis, 0);
   endtask

   initial begin
      int n, cnt, r;
      clear_model();
      repeat (2) @(negedge clk);
      chk("rst.buf_dir", buf_dir, 0);
      chk("rst.buf_addr", buf_addr, 0);
      chk("rst.ep_addr", ep_addr, 0);
      chk("rst.ep_dout", ep_dout, 0);
      chk("rst.ep_oe", ep_oe, 0);
      chk("rst.ep_prog", ep_prog, 0);
      chk("rst.ep_rd_n", ep_rd_n, 1);
      chk("rst.busy", busy, 0);
      chk("rst.done", done, 0);
      chk("rst.error", error, 0);
      chk("rst.err_addr", err_addr, 0);
      rst_n = 1'b1;

      clear_model();
      bufmem[0] = 8'hA5; bufmem[1] = 8'h3C;
      check_run("two_bytes", 2, 0);
      chk("two_bytes.ep0", eprom[0], 8'hA5);
      chk("two_bytes.ep1", eprom[1], 8'h3C);
      chk("two_bytes.npulse", npulse, 2);

      clear_model();
      check_run("noop", 0, 0);
      chk("noop.npulse", npulse, 0);

      clear_model();
      fail_cnt[1] = 2;
      check_run("retry_pass", 3, 1);

      clear_model();
      bufmem[1] = 8'h00; fail_cnt[1] = 100;
      check_run("stuck", 3, 0);
      chk("stuck.pulses1", pulses[1], 3);
      chk("stuck.pulses2", pulses[2], 0);

      for (int it = 0; it < 8; it++) begin
         clear_model();
         cnt = int'($urandom_range(1, 6));
         for (int k = 0; k < 8; k++) begin
            r = int'($urandom_range(0, 9));
            fail_cnt[k] = (r < 6) ? 0 : ((r < 9) ? r - 5 : 5);
         end
         check_run($sformatf("rand%0d", it), cnt, it[0]);
      end

      clear_model();
      check_run("clamp3000", 3000, 0);
      chk("clamp3000.npulse", npulse, DEPTH);

      clear_model();
      @(negedge clk);
      byte_count = 12'd4; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n = 0;
      while (!ep_prog && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("midrst.found_pulse", ep_prog, 1);
      repeat (2) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst.ep_prog", ep_prog, 0);
      chk("midrst.busy", busy, 0);
      chk("midrst.ep_rd_n", ep_rd_n, 1);
      chk("midrst.ep_oe", ep_oe, 0);
      chk("midrst.done", done, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      clear_model();
      check_run("after_rst", 1, 0);

      chk("pulse_width_violations", badw, 0);
      chk("oe_rd_prog_conflicts", conflict, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
